// File: rtl/vga_sync_gen_pkg.sv
// Shared timing defaults and counter helpers for the VGA sync generator.
//   - DEF_* : 640x480 @ 60 Hz timing (25 MHz pixel clock from a 100 MHz system clock)
//   - cnt_t : 10-bit unsigned pixel/line count type
//   - wrap_inc : increment with wrap to 0 after a given last value
package vga_sync_gen_pkg;

    localparam int unsigned DEF_CLK_DIV   = 4;
    localparam int unsigned DEF_H_DISPLAY = 640;
    localparam int unsigned DEF_H_FRONT   = 16;
    localparam int unsigned DEF_H_SYNC    = 96;
    localparam int unsigned DEF_H_BACK    = 48;
    localparam int unsigned DEF_V_DISPLAY = 480;
    localparam int unsigned DEF_V_FRONT   = 10;
    localparam int unsigned DEF_V_SYNC    = 2;
    localparam int unsigned DEF_V_BACK    = 33;

    localparam int unsigned CNT_W = 10;
    // Divider count width covers CLK_DIV up to 16 (count values 0..15).
    localparam int unsigned DIV_W = 4;

    typedef logic [CNT_W-1:0] cnt_t;

    function automatic cnt_t wrap_inc(input cnt_t value, input cnt_t last);
        return (value == last) ? cnt_t'(0) : value + cnt_t'(1);
    endfunction

endpackage

// File: rtl/pixel_tick_div.sv
// Mod-CLK_DIV counter producing the pixel-rate tick.
//   i_clk     : system clock
//   i_rst_n   : asynchronous active-low reset
//   o_tick_en : combinational, high in the clk cycle whose closing edge is a pixel step
//   o_p_tick  : registered one-clk pulse, high right after each pixel step edge
module pixel_tick_div
    import vga_sync_gen_pkg::*;
#(
    parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
    input  logic i_clk,
    input  logic i_rst_n,
    output logic o_tick_en,
    output logic o_p_tick
);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] r_div;
    logic             r_p_tick;

    // With CLK_DIV=1 the count is pinned at 0, so every edge is a pixel step.
    assign o_tick_en = (r_div == DIV_LAST);
    assign o_p_tick  = r_p_tick;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_div    <= '0;
            r_p_tick <= 1'b0;
        end else begin
            r_div    <= o_tick_en ? '0 : r_div + 1'b1;
            r_p_tick <= o_tick_en;
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing master: pixel-rate divider, horizontal/vertical counters and sync decode.
//   clk         : system clock
//   reset       : asynchronous active-low reset
//   p_tick      : one-clk pulse at pixel rate; counters advance on the same edge
//   pixel_x     : horizontal count 0..H_TOTAL-1
//   pixel_y     : vertical count 0..V_TOTAL-1
//   video_on    : high inside the visible area
//   hsync/vsync : active-low sync pulses
//   frame_start : one-clk pulse when the counters wrap to (0,0)
module vga_sync_gen
    import vga_sync_gen_pkg::*;
#(
    parameter int unsigned CLK_DIV   = DEF_CLK_DIV,
    parameter int unsigned H_DISPLAY = DEF_H_DISPLAY,
    parameter int unsigned H_FRONT   = DEF_H_FRONT,
    parameter int unsigned H_SYNC    = DEF_H_SYNC,
    parameter int unsigned H_BACK    = DEF_H_BACK,
    parameter int unsigned V_DISPLAY = DEF_V_DISPLAY,
    parameter int unsigned V_FRONT   = DEF_V_FRONT,
    parameter int unsigned V_SYNC    = DEF_V_SYNC,
    parameter int unsigned V_BACK    = DEF_V_BACK
) (
    input  logic       clk,
    input  logic       reset,
    output logic       p_tick,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       video_on,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_start
);

    localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam cnt_t H_LAST   = cnt_t'(H_TOTAL - 1);
    localparam cnt_t V_LAST   = cnt_t'(V_TOTAL - 1);
    localparam cnt_t H_VIS    = cnt_t'(H_DISPLAY);
    localparam cnt_t V_VIS    = cnt_t'(V_DISPLAY);
    localparam cnt_t HS_FIRST = cnt_t'(H_DISPLAY + H_FRONT);
    localparam cnt_t HS_LAST  = cnt_t'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam cnt_t VS_FIRST = cnt_t'(V_DISPLAY + V_FRONT);
    localparam cnt_t VS_LAST  = cnt_t'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic w_tick_en;
    logic w_frame_wrap;
    cnt_t w_next_x;
    cnt_t w_next_y;

    cnt_t r_x;
    cnt_t r_y;
    logic r_video_on;
    logic r_hsync;
    logic r_vsync;
    logic r_frame_start;

    pixel_tick_div #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_div (
        .i_clk     (clk),
        .i_rst_n   (reset),
        .o_tick_en (w_tick_en),
        .o_p_tick  (p_tick)
    );

    always_comb begin
        w_next_x = r_x;
        w_next_y = r_y;
        if (w_tick_en) begin
            w_next_x = wrap_inc(r_x, H_LAST);
            if (r_x == H_LAST) begin
                w_next_y = wrap_inc(r_y, V_LAST);
            end
        end
    end

    assign w_frame_wrap = w_tick_en && (r_x == H_LAST) && (r_y == V_LAST);

    // Sync and blanking are decoded from the next counts so they land on the
    // same edge as the counters themselves, with no decode skew.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_x           <= '0;
            r_y           <= '0;
            r_video_on    <= 1'b0;
            r_hsync       <= 1'b1;
            r_vsync       <= 1'b1;
            r_frame_start <= 1'b0;
        end else begin
            r_x           <= w_next_x;
            r_y           <= w_next_y;
            r_video_on    <= (w_next_x < H_VIS) && (w_next_y < V_VIS);
            r_hsync       <= !((w_next_x >= HS_FIRST) && (w_next_x <= HS_LAST));
            r_vsync       <= !((w_next_y >= VS_FIRST) && (w_next_y <= VS_LAST));
            r_frame_start <= w_frame_wrap;
        end
    end

    assign pixel_x     = r_x;
    assign pixel_y     = r_y;
    assign video_on    = r_video_on;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_sync_gen.sv
module tb_vga_sync_gen;

    // Reduced raster so whole frames fit in a short run.
    localparam int HD = 8;
    localparam int HF = 2;
    localparam int HS = 3;
    localparam int HB = 2;
    localparam int VD = 6;
    localparam int VF = 1;
    localparam int VS = 2;
    localparam int VB = 1;
    localparam int HT = HD + HF + HS + HB;
    localparam int VT = VD + VF + VS + VB;
    localparam int FRAME = HT * VT;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       d4_p_tick, d4_video_on, d4_hsync, d4_vsync, d4_frame_start;
    logic [9:0] d4_x, d4_y;
    logic       d1_p_tick, d1_video_on, d1_hsync, d1_vsync, d1_frame_start;
    logic [9:0] d1_x, d1_y;

    vga_sync_gen #(
        .CLK_DIV(4), .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
    ) u_div4 (
        .clk(clk), .reset(rst_n), .p_tick(d4_p_tick), .pixel_x(d4_x), .pixel_y(d4_y),
        .video_on(d4_video_on), .hsync(d4_hsync), .vsync(d4_vsync), .frame_start(d4_frame_start)
    );

    vga_sync_gen #(
        .CLK_DIV(1), .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
    ) u_div1 (
        .clk(clk), .reset(rst_n), .p_tick(d1_p_tick), .pixel_x(d1_x), .pixel_y(d1_y),
        .video_on(d1_video_on), .hsync(d1_hsync), .vsync(d1_vsync), .frame_start(d1_frame_start)
    );

    int n_chk = 0;
    int n_err = 0;
    int unsigned e = 0;   // clk edges since reset release; 0 while in reset

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d (edge %0d)", tag, obs, exp, e);
        end
    endtask

    // Reference: position is simply elapsed pixel ticks folded into the raster.
    task automatic check_dut(input string name, input int unsigned div,
                             input logic p, input logic [9:0] x, input logic [9:0] y,
                             input logic vid, input logic hs, input logic vs, input logic fs);
        int unsigned t, ex, ey;
        logic ep, evid, ehs, evs, efs;
        if (e == 0) begin
            ep = 1'b0; ex = 0; ey = 0; evid = 1'b0; ehs = 1'b1; evs = 1'b1; efs = 1'b0;
        end else begin
            t    = e / div;
            ep   = (e % div) == 0;
            ex   = t % HT;
            ey   = (t / HT) % VT;
            evid = (ex < HD) && (ey < VD);
            ehs  = !((ex >= HD + HF) && (ex < HD + HF + HS));
            evs  = !((ey >= VD + VF) && (ey < VD + VF + VS));
            efs  = ep && ((t % FRAME) == 0);
        end
        chk({name, ".p_tick"},      32'(p),   32'(ep));
        chk({name, ".pixel_x"},     32'(x),   ex);
        chk({name, ".pixel_y"},     32'(y),   ey);
        chk({name, ".video_on"},    32'(vid), 32'(evid));
        chk({name, ".hsync"},       32'(hs),  32'(ehs));
        chk({name, ".vsync"},       32'(vs),  32'(evs));
        chk({name, ".frame_start"}, 32'(fs),  32'(efs));
    endtask

    task automatic check_both();
        check_dut("d4", 4, d4_p_tick, d4_x, d4_y, d4_video_on, d4_hsync, d4_vsync, d4_frame_start);
        check_dut("d1", 1, d1_p_tick, d1_x, d1_y, d1_video_on, d1_hsync, d1_vsync, d1_frame_start);
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) e++;
        @(negedge clk);
        check_both();
    endtask

    int vid4_ticks = 0;
    int hs4_clks = 0;
    int fs4_count = 0;
    int first_fs4 = 0;
    int first_fs1 = 0;
    int hs1_clks = 0;

    initial begin
        rst_n = 1'b0;
        e = 0;
        repeat (3) @(negedge clk);
        check_both();

        // Release away from the clock edge: the next posedge is edge 1.
        rst_n = 1'b1;
        for (int i = 0; i < 4 * FRAME; i++) begin
            step();
            if (d4_p_tick && d4_video_on) vid4_ticks++;
            if (!d4_hsync) hs4_clks++;
            if (d4_frame_start) begin
                fs4_count++;
                if (first_fs4 == 0) first_fs4 = int'(e);
            end
            if (d1_frame_start && first_fs1 == 0) first_fs1 = int'(e);
            if (e <= FRAME && !d1_hsync) hs1_clks++;
        end
        chk("d4_video_ticks_per_frame", vid4_ticks, HD * VD);
        chk("d4_hsync_low_clks_per_frame", hs4_clks, HS * VT * 4);
        chk("d4_frame_start_count", fs4_count, 1);
        chk("d4_frame_len_clk", first_fs4, FRAME * 4);
        chk("d1_frame_len_clk", first_fs1, FRAME);
        chk("d1_hsync_low_clks_per_frame", hs1_clks, HS * VT);

        // Random mid-frame resets, asserted between edges and checked before the next edge.
        for (int k = 0; k < 5; k++) begin
            repeat ($urandom_range(20, 400)) step();
            #2 rst_n = 1'b0;
            #1 e = 0;
            check_both();
            repeat (2) step();
            rst_n = 1'b1;
        end
        repeat (50) step();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
